// File: rtl/serial_demultiplexer.sv
// Collects four addressed lane bits into a frame and holds the completed frame
// until the consumer takes it; counts delivered frames.
module serial_demultiplexer #(
    parameter int STRICT_ORDER = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_data,
    input  logic       address0,
    input  logic       address1,
    output logic       out0,
    output logic       out1,
    output logic       out2,
    output logic       out3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       order_err,
    output logic [7:0] frame_count
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic [0:0] state_reg, state_next;
    logic [3:0] stage_reg, stage_next;
    logic [3:0] mask_reg, mask_next;
    logic [3:0] outs_reg, outs_next;
    logic [1:0] expected_reg, expected_next;
    logic       out_valid_reg, out_valid_next;
    logic       order_err_reg, order_err_next;
    logic [7:0] count_reg, count_next;

    logic [1:0] lane;
    logic [3:0] lane_bit;
    logic [3:0] stage_upd;
    logic [3:0] mask_upd;

    assign lane      = {address1, address0};
    assign lane_bit  = 4'b0001 << lane;
    assign stage_upd = in_data ? (stage_reg | lane_bit) : (stage_reg & ~lane_bit);
    assign mask_upd  = mask_reg | lane_bit;

    always_comb begin
        state_next     = state_reg;
        stage_next     = stage_reg;
        mask_next      = mask_reg;
        outs_next      = outs_reg;
        expected_next  = expected_reg;
        out_valid_next = out_valid_reg;
        order_err_next = 1'b0;
        count_next     = count_reg;
        case (state_reg)
            COLLECT: begin
                if (in_valid) begin
                    stage_next = stage_upd;
                    if (STRICT_ORDER != 0) begin
                        if (lane == expected_reg) begin
                            mask_next     = mask_upd;
                            expected_next = expected_reg + 2'd1;
                        end else begin
                            // Out-of-order lane drops the partial frame; lane 0 restarts one.
                            order_err_next = 1'b1;
                            if (lane == 2'd0) begin
                                mask_next     = 4'b0001;
                                expected_next = 2'd1;
                            end else begin
                                mask_next     = 4'b0000;
                                expected_next = 2'd0;
                            end
                        end
                    end else begin
                        if (mask_reg[lane]) begin
                            order_err_next = 1'b1;
                        end
                        mask_next = mask_upd;
                    end
                    if (mask_next == 4'b1111) begin
                        outs_next      = stage_upd;
                        out_valid_next = 1'b1;
                        mask_next      = 4'b0000;
                        state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    count_next     = count_reg + 8'd1;
                    state_next     = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= COLLECT;
            stage_reg     <= 4'b0000;
            mask_reg      <= 4'b0000;
            outs_reg      <= 4'b0000;
            expected_reg  <= 2'd0;
            out_valid_reg <= 1'b0;
            order_err_reg <= 1'b0;
            count_reg     <= 8'd0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            mask_reg      <= mask_next;
            outs_reg      <= outs_next;
            expected_reg  <= expected_next;
            out_valid_reg <= out_valid_next;
            order_err_reg <= order_err_next;
            count_reg     <= count_next;
        end
    end

    assign in_ready    = (state_reg == COLLECT);
    assign out0        = outs_reg[0];
    assign out1        = outs_reg[1];
    assign out2        = outs_reg[2];
    assign out3        = outs_reg[3];
    assign out_valid   = out_valid_reg;
    assign order_err   = order_err_reg;
    assign frame_count = count_reg;

endmodule

// File: tb/tb_serial_demultiplexer.sv
// Drives a strict-order and a free-order instance with the same stimulus and
// compares both against a frame-level reference model.
module tb_serial_demultiplexer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_data = 1'b0;
    logic address0 = 1'b0;
    logic address1 = 1'b0;
    logic out_ready = 1'b0;

    logic [1:0] in_ready_w, out_valid_w, order_err_w;
    logic [1:0] out0_w, out1_w, out2_w, out3_w;
    logic [7:0] fc_w [2];

    int n_checks = 0;
    int n_errors = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    // Instance 0 enforces lane order, instance 1 accepts any order.
    serial_demultiplexer #(.STRICT_ORDER(1)) dut_strict (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .address0(address0), .address1(address1),
        .out0(out0_w[0]), .out1(out1_w[0]), .out2(out2_w[0]), .out3(out3_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .order_err(order_err_w[0]), .frame_count(fc_w[0])
    );

    serial_demultiplexer #(.STRICT_ORDER(0)) dut_loose (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .address0(address0), .address1(address1),
        .out0(out0_w[1]), .out1(out1_w[1]), .out2(out2_w[1]), .out3(out3_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .order_err(order_err_w[1]), .frame_count(fc_w[1])
    );

    // Reference model: which lanes of the current frame have arrived, their values,
    // the lane the strict sender must present next, and the delivered frame.
    bit m_hold [2];
    bit m_have [2][4];
    bit m_val  [2][4];
    int m_next [2];
    bit m_out  [2][4];
    bit m_ov   [2];
    bit m_err  [2];
    int m_cnt  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_hold[m] = 0; m_ov[m] = 0; m_err[m] = 0; m_cnt[m] = 0; m_next[m] = 0;
            for (int l = 0; l < 4; l++) begin
                m_have[m][l] = 0; m_val[m][l] = 0; m_out[m][l] = 0;
            end
        end
    endfunction

    function automatic void model_step(int m, bit v, bit d, int lane, bit ordy);
        m_err[m] = 0;
        if (!m_hold[m]) begin
            if (v) begin
                if (m == 0) begin
                    if (lane != m_next[m]) begin
                        m_err[m] = 1;
                        for (int l = 0; l < 4; l++) m_have[m][l] = 0;
                        if (lane == 0) begin
                            m_have[m][0] = 1; m_val[m][0] = d; m_next[m] = 1;
                        end else begin
                            m_next[m] = 0;
                        end
                    end else begin
                        m_have[m][lane] = 1; m_val[m][lane] = d;
                        m_next[m] = (m_next[m] + 1) % 4;
                    end
                end else begin
                    if (m_have[m][lane]) m_err[m] = 1;
                    m_have[m][lane] = 1; m_val[m][lane] = d;
                end
                if (m_have[m][0] && m_have[m][1] && m_have[m][2] && m_have[m][3]) begin
                    for (int l = 0; l < 4; l++) begin
                        m_out[m][l] = m_val[m][l]; m_have[m][l] = 0;
                    end
                    m_ov[m] = 1; m_hold[m] = 1;
                end
            end
        end else if (ordy) begin
            m_ov[m] = 0; m_hold[m] = 0; m_cnt[m] = (m_cnt[m] + 1) % 256;
        end
    endfunction

    function automatic logic [14:0] observed(int m);
        return {in_ready_w[m], out_valid_w[m], order_err_w[m],
                out3_w[m], out2_w[m], out1_w[m], out0_w[m], fc_w[m]};
    endfunction

    function automatic logic [14:0] expected(int m);
        logic [7:0] c;
        c = m_cnt[m][7:0];
        return {~m_hold[m], m_ov[m], m_err[m],
                m_out[m][3], m_out[m][2], m_out[m][1], m_out[m][0], c};
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, "_strict"}, 32'(observed(0)), 32'(expected(0)));
        check_eq({tag, "_loose"},  32'(observed(1)), 32'(expected(1)));
    endtask

    task automatic step(input bit v, input bit d, input int lane, input bit ordy);
        in_valid  = v;
        in_data   = d;
        address0  = lane[0];
        address1  = lane[1];
        out_ready = ordy;
        @(posedge clk);
        model_step(0, v, d, lane, ordy);
        model_step(1, v, d, lane, ordy);
        #1;
        n_txn++;
        $display("txn %0d v=%0d lane=%0d d=%0d out_ready=%0d | strict ov=%0b err=%0b fc=%0d | loose ov=%0b err=%0b fc=%0d",
                 n_txn, v, lane, d, ordy, out_valid_w[0], order_err_w[0], fc_w[0],
                 out_valid_w[1], order_err_w[1], fc_w[1]);
        compare_all("step");
    endtask

    // Asserts reset between clock edges and holds it across one rising edge.
    task automatic mid_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("rst_async");
        check_eq("rst_in_ready", 32'(in_ready_w), 32'd3);
        @(posedge clk);
        #1;
        compare_all("rst_held");
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bit d;
        model_reset();
        #2;
        compare_all("reset");
        check_eq("reset_in_ready", 32'(in_ready_w), 32'd3);
        #10;
        rst_n = 1'b1;

        // In-order frame 1,0,1,1
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        step(1, 1, 2, 0);
        check_eq("s032_not_yet", 32'(out_valid_w[0]), 32'd0);
        step(1, 1, 3, 0);
        check_eq("s032_valid", 32'(out_valid_w[0]), 32'd1);
        check_eq("s032_data", 32'({out3_w[0], out2_w[0], out1_w[0], out0_w[0]}), 32'hD);
        check_eq("s032_no_err", 32'(order_err_w[0]), 32'd0);

        // Backpressure in HOLD while the sender keeps pushing
        for (int i = 0; i < 5; i++) begin
            step(1, i[0], i % 4, 0);
            check_eq("s033_in_ready", 32'(in_ready_w[0]), 32'd0);
            check_eq("s033_stable", 32'({out_valid_w[0], out3_w[0], out2_w[0], out1_w[0], out0_w[0]}), 32'h1D);
        end
        step(0, 0, 0, 1);
        check_eq("s033_delivered", 32'(out_valid_w[0]), 32'd0);
        check_eq("s033_count", 32'(fc_w[0]), 32'd1);

        // Strict order violation followed by a clean frame
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 3, 0);
        check_eq("s034_err", 32'(order_err_w[0]), 32'd1);
        step(1, 0, 0, 0);
        check_eq("s034_err_clear", 32'(order_err_w[0]), 32'd0);
        step(1, 1, 1, 0);
        step(1, 1, 2, 0);
        step(1, 0, 3, 0);
        check_eq("s034_complete", 32'(out_valid_w[0]), 32'd1);
        check_eq("s034_data", 32'({out3_w[0], out2_w[0], out1_w[0], out0_w[0]}), 32'h6);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Free order with a duplicate lane
        step(1, 1, 2, 0);
        step(1, 1, 0, 0);
        step(1, 0, 2, 0);
        check_eq("s035_dup_err", 32'(order_err_w[1]), 32'd1);
        step(1, 1, 3, 0);
        check_eq("s035_not_yet", 32'(out_valid_w[1]), 32'd0);
        step(1, 1, 1, 0);
        check_eq("s035_complete", 32'(out_valid_w[1]), 32'd1);
        check_eq("s035_out2", 32'(out2_w[1]), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Frame counter wrap from a clean reset
        mid_reset();
        for (int f = 0; f < 256; f++) begin
            for (int l = 0; l < 4; l++) begin
                d = 1'($urandom_range(0, 1));
                step(1, d, l, 0);
            end
            step(0, 0, 0, 1);
            if (f == 254) check_eq("s036_count_255", 32'(fc_w[0]), 32'd255);
        end
        check_eq("s036_wrap_strict", 32'(fc_w[0]), 32'd0);
        check_eq("s036_wrap_loose", 32'(fc_w[1]), 32'd0);

        // Reset in the middle of a partial frame
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        mid_reset();
        check_eq("s037_outs", 32'({out_valid_w, order_err_w, out0_w, out1_w}), 32'd0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 2, 0);
        step(1, 0, 3, 0);
        check_eq("s037_complete", 32'(out_valid_w), 32'd3);
        check_eq("s037_data", 32'({out3_w[0], out2_w[0], out1_w[0], out0_w[0]}), 32'h6);
        step(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_demultiplexer.md
SERIAL_DEMULTIPLEXER -- requirements
Module: serial_demultiplexer

Parameters
REQ-001 The block SHALL have a parameter STRICT_ORDER, default 1, which when 1 requires lane addresses in order 0,1,2,3 and when 0 accepts any order.

Interface
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have a port in_valid, input, 1 bit: the sender presents a lane bit this cycle.
REQ-005 The block SHALL have a port in_ready, output, 1 bit: the block accepts a lane bit this cycle; it is high exactly when the state is COLLECT.
REQ-006 The block SHALL have a port in_data, input, 1 bit: the lane bit value.
REQ-007 The block SHALL have a port address0, input, 1 bit: lane select LSB.
REQ-008 The block SHALL have a port address1, input, 1 bit: lane select MSB; lane = {address1,address0}.
REQ-009 The block SHALL have ports out0, out1, out2 and out3, output, 1 bit each: the registered lane values of the last completed frame.
REQ-010 The block SHALL have a port out_valid, output, 1 bit: out0..out3 hold an undelivered frame.
REQ-011 The block SHALL have a port out_ready, input, 1 bit: the consumer takes the frame.
REQ-012 The block SHALL have a port order_err, output, 1 bit: one-cycle pulse on an order violation or duplicate lane.
REQ-013 The block SHALL have a port frame_count, output, 8 bits: count of delivered frames, wrapping 255 -> 0.

Function
REQ-014 The block SHALL implement two states: COLLECT and HOLD.
REQ-015 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; with in_valid=0, state, staging and mask SHALL be unchanged.
REQ-016 The internal state SHALL comprise a 4-bit staging register, a 4-bit written mask and, when STRICT_ORDER=1, a 2-bit expected-lane counter.
REQ-017 On an accepted transfer to lane L, the block SHALL set stage[L] to in_data and mask[L] to 1.
REQ-018 If the updated mask equals 1111, the block SHALL, on the same edge, copy the staging register including the new bit into out0..out3, set out_valid to 1, clear the mask and enter HOLD; latency from the final lane bit to out_valid is 1 cycle.
REQ-019 When STRICT_ORDER=1 and L differs from the expected lane, the block SHALL pulse order_err for one cycle and discard the partial frame by clearing the mask.
REQ-020 Following such a mismatch, if L=0 the bit SHALL be accepted as lane 0 of a new frame with expected set to 1; otherwise expected SHALL be set to 0.
REQ-021 When STRICT_ORDER=1 and L matches the expected lane, expected SHALL increment, wrapping 3 -> 0 at frame completion.
REQ-022 When STRICT_ORDER=0 and mask[L] is already 1, the block SHALL pulse order_err, overwrite stage[L] and leave the mask unchanged.
REQ-023 In HOLD, in_ready SHALL be 0 and in_valid SHALL be ignored (no transfer, no order_err).
REQ-024 In HOLD with out_ready=1, out_valid SHALL fall to 0 on the next edge, frame_count SHALL increment and the state SHALL return to COLLECT.
REQ-025 out0..out3 SHALL retain their values after delivery until the next frame completes.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 While rst_n=0, the block SHALL immediately, independent of clk, enter COLLECT.
REQ-028 While rst_n=0, the block SHALL clear the staging register, mask, expected counter, out0..out3, out_valid, order_err and frame_count.
REQ-029 While rst_n=0, in_ready SHALL be 1.
REQ-030 Reset asserted during a partial frame or in HOLD SHALL discard the frame with no order_err.
REQ-031 The first transfer SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-032 The bench SHALL cover: STRICT_ORDER=1, lanes 0,1,2,3 with data 1,0,1,1 -> out_valid=1 one cycle after the fourth transfer, out0..out3 = 1,0,1,1, order_err never pulses.
REQ-033 The bench SHALL cover: holding out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 -> out_valid=0 and frame_count=1 on the next edge.
REQ-034 The bench SHALL cover: STRICT_ORDER=1, lanes 0,1,3 -> order_err pulses on lane 3, mask cleared; a following lane 0,1,2,3 sequence completes normally.
REQ-035 The bench SHALL cover: STRICT_ORDER=0, lanes 2,0,2(data 0),3,1 -> order_err on the second lane 2; frame completes on lane 1 with out2=0.
REQ-036 The bench SHALL cover: 256 delivered frames -> frame_count wraps to 0.
REQ-037 The bench SHALL cover: rst_n low mid-clock after two lanes are accepted -> all outputs 0 immediately, in_ready=1, and a fresh four-lane frame completes normally.
